// File: rtl/simple_axi_read_arbiter.sv
// N_REQ-to-1 simple read-port arbiter; round-robin, or fixed priority when SIMPLE_AXI_READ_ARB_FIXED_PRIO_EN is defined.
// Grant/request registered one cycle after sampling; beats pass through combinationally with no backpressure.
module simple_axi_read_arbiter #(
  parameter int N_REQ      = 4,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [N_REQ-1:0]              s_rvalid_i,
  input  logic [N_REQ*AXI_ADDR_W-1:0]   s_raddr_i,
  input  logic [N_REQ*LEN_W-1:0]        s_rlen_i,
  output logic [N_REQ-1:0]              s_rready_o,
  output logic [AXI_DATA_W-1:0]         s_rdata_o,
  output logic [N_REQ-1:0]              s_rlast_o,
  output logic                          m_rvalid_o,
  output logic [AXI_ADDR_W-1:0]         m_raddr_o,
  output logic [LEN_W-1:0]              m_rlen_o,
  input  logic                          m_rready_i,
  input  logic [AXI_DATA_W-1:0]         m_rdata_i,
  input  logic                          m_rlast_i,
  output logic [N_REQ-1:0]              grant_o,
  output logic                          error_o
);
  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [LEN_W-1:0]      len;
  } req_t;

  state_t           state_q, state_d;
  req_t             req_q, req_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic [PTR_W-1:0] ptr;
  logic             win_vld;
  logic [PTR_W-1:0] win_idx;
  logic             done;

  assign done = m_rready_i & m_rlast_i;

`ifdef SIMPLE_AXI_READ_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Pointer moves past the winner only once its transfer completes.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == BUSY && done)
      ptr_d = (idx_q == PTR_W'(N_REQ-1)) ? '0 : idx_q + PTR_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`endif

  // Scan from the far end so the requester closest to ptr overwrites the rest.
  always_comb begin
    int j;
    j       = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N_REQ;
      if (s_rvalid_i[j]) begin
        win_vld = 1'b1;
        win_idx = PTR_W'(j);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = BUSY;
      BUSY:    if (done)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d   = req_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    err_d   = err_q | ((state_q == IDLE) & m_rready_i);
    if (state_q == IDLE && win_vld) begin
      idx_d    = win_idx;
      grant_d  = N_REQ'(1) << win_idx;
      req_d.addr = s_raddr_i[win_idx*AXI_ADDR_W +: AXI_ADDR_W];
      req_d.len  = s_rlen_i[win_idx*LEN_W +: LEN_W];
    end else if (state_q == BUSY && done) begin
      grant_d = '0;
    end
  end

  always_comb begin
    m_rvalid_o = (state_q == BUSY);
    m_raddr_o  = req_q.addr;
    m_rlen_o   = req_q.len;
    grant_o    = grant_q;
    error_o    = err_q;
    s_rdata_o  = m_rdata_i;
    s_rready_o = {N_REQ{m_rready_i}} & grant_q;
    s_rlast_o  = {N_REQ{done}} & grant_q;
  end

endmodule

// File: tb/tb_simple_axi_read_arbiter.sv
// Directed bench for simple_axi_read_arbiter: grant order, hold, error and reset behaviour.
module tb_simple_axi_read_arbiter;
  localparam int N = 4, AW = 32, DW = 32, LW = 8;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic [N-1:0]    s_rvalid_i;
  logic [N*AW-1:0] s_raddr_i;
  logic [N*LW-1:0] s_rlen_i;
  logic [N-1:0]    s_rready_o;
  logic [DW-1:0]   s_rdata_o;
  logic [N-1:0]    s_rlast_o;
  logic            m_rvalid_o;
  logic [AW-1:0]   m_raddr_o;
  logic [LW-1:0]   m_rlen_o;
  logic            m_rready_i;
  logic [DW-1:0]   m_rdata_i;
  logic            m_rlast_i;
  logic [N-1:0]    grant_o;
  logic            error_o;

  int total = 0;
  int bad   = 0;

  simple_axi_read_arbiter #(.N_REQ(N), .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .LEN_W(LW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .s_rvalid_i(s_rvalid_i), .s_raddr_i(s_raddr_i), .s_rlen_i(s_rlen_i),
    .s_rready_o(s_rready_o), .s_rdata_o(s_rdata_o), .s_rlast_o(s_rlast_o),
    .m_rvalid_o(m_rvalid_o), .m_raddr_o(m_raddr_o), .m_rlen_o(m_rlen_o),
    .m_rready_i(m_rready_i), .m_rdata_i(m_rdata_i), .m_rlast_i(m_rlast_i),
    .grant_o(grant_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
    s_raddr_i[i*AW +: AW] = a;
    s_rlen_i[i*LW +: LW]  = l;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0; m_rready_i = 1'b0; m_rlast_i = 1'b0;
    step(); step();
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    step(); step();
    total++; if (grant_o !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant_o); end
    total++; if (m_rvalid_o !== 1'b0) begin bad++; $display("FAIL reset_mvalid got=%b want=0", m_rvalid_o); end
    total++; if (m_raddr_o !== 32'h0 || m_rlen_o !== 8'h0) begin bad++; $display("FAIL reset_req got=%h/%h want=0/0", m_raddr_o, m_rlen_o); end
    total++; if (error_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", error_o); end
    total++; if (s_rready_o !== 4'b0 || s_rlast_o !== 4'b0) begin bad++; $display("FAIL reset_srdy got=%b/%b want=0000/0000", s_rready_o, s_rlast_o); end
    rst_n_i = 1'b1;
  endtask

  task automatic test_single();
    logic [N-1:0] exp_last;
    s_rvalid_i = 4'b0100;
    set_req(2, 32'h1000, 8'd16);
    step();
    total++; if (grant_o !== 4'b0100 || m_rvalid_o !== 1'b1) begin bad++; $display("FAIL single_grant got=%b/%b want=0100/1", grant_o, m_rvalid_o); end
    total++; if (m_raddr_o !== 32'h1000 || m_rlen_o !== 8'd16) begin bad++; $display("FAIL single_req got=%h/%0d want=1000/16", m_raddr_o, m_rlen_o); end
    for (int b = 1; b <= 4; b++) begin
      m_rready_i = 1'b1; m_rlast_i = (b == 4); m_rdata_i = 32'h11 * b;
      exp_last = (b == 4) ? 4'b0100 : 4'b0000;
      #1;
      total++; if (s_rready_o !== 4'b0100) begin bad++; $display("FAIL single_rdy beat%0d got=%b want=0100", b, s_rready_o); end
      total++; if (s_rlast_o !== exp_last) begin bad++; $display("FAIL single_last beat%0d got=%b want=%b", b, s_rlast_o, exp_last); end
      total++; if (s_rdata_o !== 32'h11 * b) begin bad++; $display("FAIL single_data beat%0d got=%h want=%h", b, s_rdata_o, 32'h11 * b); end
      step();
    end
    m_rready_i = 1'b0; m_rlast_i = 1'b0; s_rvalid_i = 4'b0000;
    total++; if (grant_o !== 4'b0000 || m_rvalid_o !== 1'b0) begin bad++; $display("FAIL single_after got=%b/%b want=0000/0", grant_o, m_rvalid_o); end
  endtask

  task automatic test_contention();
    int exp_order[4];
`ifdef SIMPLE_AXI_READ_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 3, 0};
`endif
    rst_n_i = 1'b0;
    s_rvalid_i = 4'b1011;
    for (int i = 0; i < N; i++) set_req(i, 32'h100 * (i + 1), 8'd4);
    do_reset();
    for (int n = 0; n < 4; n++) begin
      step();
      total++; if (grant_o !== 4'(1 << exp_order[n])) begin bad++; $display("FAIL cont_grant%0d got=%b want=%b", n, grant_o, 4'(1 << exp_order[n])); end
      total++; if (m_raddr_o !== 32'h100 * (exp_order[n] + 1)) begin bad++; $display("FAIL cont_addr%0d got=%h want=%h", n, m_raddr_o, 32'h100 * (exp_order[n] + 1)); end
      m_rready_i = 1'b1; m_rlast_i = 1'b1;
      #1;
      total++; if (s_rlast_o !== 4'(1 << exp_order[n])) begin bad++; $display("FAIL cont_last%0d got=%b want=%b", n, s_rlast_o, 4'(1 << exp_order[n])); end
      step();
      m_rready_i = 1'b0; m_rlast_i = 1'b0;
      total++; if (grant_o !== 4'b0000 || m_rvalid_o !== 1'b0) begin bad++; $display("FAIL cont_gap%0d got=%b/%b want=0000/0", n, grant_o, m_rvalid_o); end
    end
    s_rvalid_i = 4'b0000;
  endtask

  task automatic test_wrap();
    logic [N-1:0] exp_first, exp_second;
`ifdef SIMPLE_AXI_READ_ARB_FIXED_PRIO_EN
    exp_first = 4'b0001; exp_second = 4'b1000;
`else
    exp_first = 4'b1000; exp_second = 4'b0001;
`endif
    s_rvalid_i = 4'b0100;
    step();
    total++; if (grant_o !== 4'b0100) begin bad++; $display("FAIL wrap_setup got=%b want=0100", grant_o); end
    s_rvalid_i = 4'b0000; m_rready_i = 1'b1; m_rlast_i = 1'b1;
    step();
    m_rready_i = 1'b0; m_rlast_i = 1'b0; s_rvalid_i = 4'b1001;
    step();
    total++; if (grant_o !== exp_first) begin bad++; $display("FAIL wrap_first got=%b want=%b", grant_o, exp_first); end
    s_rvalid_i = s_rvalid_i & ~exp_first; m_rready_i = 1'b1; m_rlast_i = 1'b1;
    step();
    m_rready_i = 1'b0; m_rlast_i = 1'b0;
    step();
    total++; if (grant_o !== exp_second) begin bad++; $display("FAIL wrap_second got=%b want=%b", grant_o, exp_second); end
    s_rvalid_i = 4'b0000; m_rready_i = 1'b1; m_rlast_i = 1'b1;
    step();
    m_rready_i = 1'b0; m_rlast_i = 1'b0;
  endtask

  task automatic test_hold();
    s_rvalid_i = 4'b0001;
    set_req(0, 32'h2000, 8'd8);
    step();
    total++; if (m_raddr_o !== 32'h2000 || m_rlen_o !== 8'd8 || grant_o !== 4'b0001) begin bad++; $display("FAIL hold_latch got=%h/%0d/%b want=2000/8/0001", m_raddr_o, m_rlen_o, grant_o); end
    set_req(0, 32'hDEAD, 8'h55);
    s_rvalid_i = 4'b0000;
    step(); step(); step();
    total++; if (m_raddr_o !== 32'h2000 || m_rlen_o !== 8'd8) begin bad++; $display("FAIL hold_stable got=%h/%0d want=2000/8", m_raddr_o, m_rlen_o); end
    total++; if (grant_o !== 4'b0001 || m_rvalid_o !== 1'b1) begin bad++; $display("FAIL hold_busy got=%b/%b want=0001/1", grant_o, m_rvalid_o); end
    m_rready_i = 1'b1; m_rlast_i = 1'b0;
    step();
    total++; if (m_raddr_o !== 32'h2000 || grant_o !== 4'b0001) begin bad++; $display("FAIL hold_midbeat got=%h/%b want=2000/0001", m_raddr_o, grant_o); end
    m_rlast_i = 1'b1;
    step();
    m_rready_i = 1'b0; m_rlast_i = 1'b0;
    total++; if (grant_o !== 4'b0000 || m_rvalid_o !== 1'b0) begin bad++; $display("FAIL hold_done got=%b/%b want=0000/0", grant_o, m_rvalid_o); end
  endtask

  task automatic test_error();
    total++; if (error_o !== 1'b0) begin bad++; $display("FAIL err_pre got=%b want=0", error_o); end
    m_rready_i = 1'b1; m_rdata_i = 32'hBAD0;
    #1;
    total++; if (s_rready_o !== 4'b0000) begin bad++; $display("FAIL err_srdy got=%b want=0000", s_rready_o); end
    step();
    m_rready_i = 1'b0;
    total++; if (error_o !== 1'b1) begin bad++; $display("FAIL err_set got=%b want=1", error_o); end
    step(); step();
    total++; if (error_o !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b want=1", error_o); end
  endtask

  task automatic test_reset_mid();
    s_rvalid_i = 4'b0100;
    set_req(2, 32'h3000, 8'd16);
    step();
    s_rvalid_i = 4'b0000; m_rready_i = 1'b1; m_rlast_i = 1'b1;
    step();
    m_rready_i = 1'b0; m_rlast_i = 1'b0;
    s_rvalid_i = 4'b1000;
    set_req(3, 32'h4000, 8'd16);
    step();
    total++; if (grant_o !== 4'b1000) begin bad++; $display("FAIL rmid_grant got=%b want=1000", grant_o); end
    s_rvalid_i = 4'b1010;
    set_req(1, 32'h5000, 8'd4);
    m_rready_i = 1'b1; m_rlast_i = 1'b0;
    step();
    #1;
    total++; if (s_rready_o !== 4'b1000) begin bad++; $display("FAIL rmid_beat2 got=%b want=1000", s_rready_o); end
    #1 rst_n_i = 1'b0;
    #1;
    total++; if (grant_o !== 4'b0000 || m_rvalid_o !== 1'b0) begin bad++; $display("FAIL rmid_clear got=%b/%b want=0000/0", grant_o, m_rvalid_o); end
    total++; if (m_raddr_o !== 32'h0 || m_rlen_o !== 8'h0 || error_o !== 1'b0) begin bad++; $display("FAIL rmid_regs got=%h/%h/%b want=0/0/0", m_raddr_o, m_rlen_o, error_o); end
    total++; if (s_rready_o !== 4'b0000 || s_rlast_o !== 4'b0000) begin bad++; $display("FAIL rmid_srdy got=%b/%b want=0000/0000", s_rready_o, s_rlast_o); end
    m_rready_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    step();
    total++; if (grant_o !== 4'b0010 || m_raddr_o !== 32'h5000) begin bad++; $display("FAIL rmid_regrant got=%b/%h want=0010/5000", grant_o, m_raddr_o); end
    s_rvalid_i = 4'b0000; m_rready_i = 1'b1; m_rlast_i = 1'b1;
    step();
    m_rready_i = 1'b0; m_rlast_i = 1'b0;
  endtask

  initial begin
    rst_n_i = 1'b0; s_rvalid_i = '0; s_raddr_i = '0; s_rlen_i = '0;
    m_rready_i = 1'b0; m_rdata_i = '0; m_rlast_i = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_hold();
    test_error();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
